// File: rtl/mask_streamer.sv
// Two-bank frame buffer that captures a 1-bit camera mask and replays it as a gapless raster
// stream to the k-means engine. Optional drop counter: define MASK_STREAMER_STATS_EN.
module mask_streamer #(
    parameter int unsigned WIDTH  = 320,
    parameter int unsigned HEIGHT = 180
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       mask_in,
    input  logic [8:0] hcount_in,
    input  logic [7:0] vcount_in,
    input  logic       pixel_valid_in,
    input  logic       frame_done_in,
    input  logic       kmeans_done_in,
    output logic [8:0] x_out,
    output logic [7:0] y_out,
    output logic       data_valid_out,
    output logic       new_frame_out,
    output logic       busy_out,
    output logic [7:0] frames_dropped_out
);

    localparam int unsigned WordsPerRow = WIDTH / 64;
    localparam int unsigned BankWords   = HEIGHT * WordsPerRow;
    localparam int unsigned AddrW       = $clog2(2 * BankWords);

    localparam logic [8:0]       XLast     = 9'(WIDTH - 1);
    localparam logic [7:0]       YLast     = 8'(HEIGHT - 1);
    localparam logic [7:0]       YFlag     = 8'(HEIGHT);
    localparam logic [AddrW-1:0] Bank1Base = AddrW'(BankWords);

    typedef enum logic [1:0] {StIdle, StStream, StFlag, StWaitDone} state_e;

    state_e state_q;

    logic pend_q;
    logic rd_q;
    logic wb_q;
    logic rbank_q;

    // ---------------- write side ----------------
    logic             in_range;
    logic             wr_pix;
    logic             wr_word;
    logic [63:0]      asm_q;
    logic [63:0]      wr_data;
    logic [AddrW-1:0] wr_addr;

    assign in_range = ({1'b0, hcount_in} < 10'(WIDTH)) && ({1'b0, vcount_in} < 9'(HEIGHT));
    assign wr_pix   = pixel_valid_in && in_range;
    assign wr_word  = wr_pix && (hcount_in[5:0] == 6'd63);
    assign wr_addr  = (wb_q ? Bank1Base : '0)
                    + AddrW'(vcount_in) * AddrW'(WordsPerRow)
                    + AddrW'(hcount_in[8:6]);

    always_comb begin
        wr_data     = asm_q;
        wr_data[63] = mask_in;
    end

    // Cleared after each word write so a word never inherits bits from its predecessor.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            asm_q <= '0;
        end else if (wr_word) begin
            asm_q <= '0;
        end else if (wr_pix) begin
            asm_q[hcount_in[5:0]] <= mask_in;
        end
    end

    // ---------------- storage ----------------
    logic [63:0]      mem [2*BankWords];
    logic [AddrW-1:0] rd_addr;
    logic [63:0]      rd_word1;
    logic [63:0]      rd_word2;

    always_ff @(posedge clk_in) begin
        if (wr_word) begin
            mem[wr_addr] <= wr_data;
        end
        rd_word1 <= mem[rd_addr];
    end

    // ---------------- read pipeline ----------------
    logic       issue_q;
    logic [8:0] x0_q;
    logic [7:0] y0_q;
    logic       v1_q, v2_q;
    logic [8:0] x1_q, x2_q;
    logic [7:0] y1_q, y2_q;
    logic       last_q;

    assign rd_addr = (rbank_q ? Bank1Base : '0)
                   + AddrW'(y0_q) * AddrW'(WordsPerRow)
                   + AddrW'(x0_q[8:6]);

    // One word read per pixel keeps the pipeline uniform; the word is reused across 64 pixels.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            x1_q     <= '0;
            y1_q     <= '0;
            x2_q     <= '0;
            y2_q     <= '0;
            rd_word2 <= '0;
        end else begin
            v1_q     <= issue_q;
            x1_q     <= x0_q;
            y1_q     <= y0_q;
            v2_q     <= v1_q;
            x2_q     <= x1_q;
            y2_q     <= y1_q;
            rd_word2 <= rd_word1;
        end
    end

    // ---------------- control FSM and registered outputs ----------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q        <= StIdle;
            pend_q         <= 1'b0;
            rd_q           <= 1'b0;
            wb_q           <= 1'b0;
            rbank_q        <= 1'b0;
            issue_q        <= 1'b0;
            x0_q           <= '0;
            y0_q           <= '0;
            last_q         <= 1'b0;
            x_out          <= '0;
            y_out          <= '0;
            data_valid_out <= 1'b0;
            new_frame_out  <= 1'b0;
            busy_out       <= 1'b0;
        end else begin
            new_frame_out  <= 1'b0;
            data_valid_out <= v2_q && rd_word2[x2_q[5:0]];
            last_q         <= v2_q && (x2_q == XLast) && (y2_q == YLast);
            if (v2_q) begin
                x_out <= x2_q;
                y_out <= y2_q;
            end

            if (frame_done_in && !pend_q && !rd_q) begin
                wb_q   <= !wb_q;
                pend_q <= 1'b1;
            end

            if (issue_q) begin
                if (x0_q == XLast) begin
                    x0_q <= '0;
                    if (y0_q == YLast) begin
                        issue_q <= 1'b0;
                    end else begin
                        y0_q <= y0_q + 8'd1;
                    end
                end else begin
                    x0_q <= x0_q + 9'd1;
                end
            end

            unique case (state_q)
                StIdle: begin
                    if (pend_q) begin
                        pend_q   <= 1'b0;
                        rd_q     <= 1'b1;
                        rbank_q  <= !wb_q;
                        issue_q  <= 1'b1;
                        x0_q     <= '0;
                        y0_q     <= '0;
                        busy_out <= 1'b1;
                        state_q  <= StStream;
                    end
                end
                StStream: begin
                    // last_q marks the cycle the final pixel sits in the output register.
                    if (last_q) begin
                        rd_q           <= 1'b0;
                        new_frame_out  <= 1'b1;
                        x_out          <= '0;
                        y_out          <= YFlag;
                        data_valid_out <= 1'b0;
                        state_q        <= StFlag;
                    end
                end
                StFlag: begin
                    state_q <= StWaitDone;
                end
                StWaitDone: begin
                    if (kmeans_done_in) begin
                        busy_out <= 1'b0;
                        state_q  <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // ---------------- drop statistics ----------------
`ifdef MASK_STREAMER_STATS_EN
    logic       drop;
    logic [7:0] drops_q;

    assign drop = frame_done_in && (pend_q || rd_q);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            drops_q <= '0;
        end else if (drop && (drops_q != 8'hff)) begin
            drops_q <= drops_q + 8'd1;
        end
    end

    assign frames_dropped_out = drops_q;
`else
    assign frames_dropped_out = '0;
`endif

endmodule

// File: tb/tb_mask_streamer.sv
// Directed bench for mask_streamer on a reduced 128x6 frame so every stream is fully checked.
module tb_mask_streamer;

    localparam int W = 128;
    localparam int H = 6;

`ifdef MASK_STREAMER_STATS_EN
    localparam bit StatsEn = 1'b1;
`else
    localparam bit StatsEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_in = 1'b1;
    logic       mask_in = 1'b0;
    logic [8:0] hcount_in = '0;
    logic [7:0] vcount_in = '0;
    logic       pixel_valid_in = 1'b0;
    logic       frame_done_in = 1'b0;
    logic       kmeans_done_in = 1'b0;
    logic [8:0] x_out;
    logic [7:0] y_out;
    logic       data_valid_out;
    logic       new_frame_out;
    logic       busy_out;
    logic [7:0] frames_dropped_out;

    int n_checks = 0;
    int n_pass   = 0;

    mask_streamer #(
        .WIDTH (W),
        .HEIGHT(H)
    ) dut (
        .clk_in            (clk),
        .rst_in            (rst_in),
        .mask_in           (mask_in),
        .hcount_in         (hcount_in),
        .vcount_in         (vcount_in),
        .pixel_valid_in    (pixel_valid_in),
        .frame_done_in     (frame_done_in),
        .kmeans_done_in    (kmeans_done_in),
        .x_out             (x_out),
        .y_out             (y_out),
        .data_valid_out    (data_valid_out),
        .new_frame_out     (new_frame_out),
        .busy_out          (busy_out),
        .frames_dropped_out(frames_dropped_out)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic bit pat(input int kind, input int x, input int y);
        case (kind)
            0:       return (x == 100) && (y == 5);
            1:       return 1'b1;
            2:       return ((x + y) % 3) == 0;
            3:       return (x % 5) == (y % 5);
            4:       return x < y * 20;
            default: return (((x + 2 * y) % 7) == 0) && ((x % 64) != 10);
        endcase
    endfunction

    // oor inserts out-of-range mask=1 pixels that alias bit 10 of the word being assembled.
    task automatic write_frame(input int kind, input bit oor);
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                pixel_valid_in = 1'b1;
                hcount_in      = 9'(x);
                vcount_in      = 8'(y);
                mask_in        = pat(kind, x, y);
                tick();
                if (oor && ((x % 64) == 10)) begin
                    hcount_in = 9'(W + x);
                    mask_in   = 1'b1;
                    tick();
                    hcount_in = 9'(x);
                    vcount_in = 8'(H);
                    tick();
                end
            end
        end
        pixel_valid_in = 1'b0;
        mask_in        = 1'b0;
        frame_done_in  = 1'b1;
        tick();
        frame_done_in  = 1'b0;
    endtask

    task automatic pulse_kmeans_done;
        kmeans_done_in = 1'b1;
        tick();
        kmeans_done_in = 1'b0;
    endtask

    // Entered at or before STREAM entry; returns in the WAIT_DONE cycle after FLAG.
    task automatic run_stream(input int kind, input string tag);
        int wait_n = 0;
        int bad = 0;
        int ones = 0;
        int exp_ones = 0;
        while (!busy_out && wait_n < 3000) begin
            tick();
            wait_n++;
        end
        check({tag, "_start"}, 32'(busy_out), 32'd1);
        repeat (2) tick();
        check({tag, "_pre_dv"}, 32'(data_valid_out), 32'd0);
        tick();
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                if (x_out != 9'(x) || y_out != 8'(y) || data_valid_out != pat(kind, x, y)) bad++;
                if (data_valid_out) ones++;
                if (pat(kind, x, y)) exp_ones++;
                tick();
            end
        end
        check({tag, "_mism"}, 32'(bad), 32'd0);
        check({tag, "_ones"}, 32'(ones), 32'(exp_ones));
        check({tag, "_flag"}, {13'd0, new_frame_out, data_valid_out, x_out, y_out},
              {13'd0, 1'b1, 1'b0, 9'd0, 8'(H)});
        tick();
        check({tag, "_wait"}, {30'd0, new_frame_out, busy_out}, {30'd0, 1'b0, 1'b1});
    endtask

    initial begin
        int viol;

        repeat (3) tick();
        rst_in = 1'b0;
        check("rst_x", 32'(x_out), 32'd0);
        check("rst_y", 32'(y_out), 32'd0);
        check("rst_dv", 32'(data_valid_out), 32'd0);
        check("rst_nf", 32'(new_frame_out), 32'd0);
        check("rst_busy", 32'(busy_out), 32'd0);
        check("rst_drops", 32'(frames_dropped_out), 32'd0);

        // Single pixel: stream starts two cycles after frame_done.
        write_frame(0, 1'b0);
        check("single_idle", 32'(busy_out), 32'd0);
        tick();
        check("single_entry", 32'(busy_out), 32'd1);
        run_stream(0, "single");
        pulse_kmeans_done();
        check("single_release", 32'(busy_out), 32'd0);

        // Full frame: every cycle valid, raster order.
        write_frame(1, 1'b0);
        run_stream(1, "full");

        // Queued frame completes during WAIT_DONE; nothing streams until kmeans_done.
        write_frame(2, 1'b0);
        viol = 0;
        for (int i = 0; i < 20; i++) begin
            if (data_valid_out || new_frame_out || !busy_out) viol++;
            tick();
        end
        check("queued_hold", 32'(viol), 32'd0);
        pulse_kmeans_done();
        check("queued_idle", 32'(busy_out), 32'd0);
        tick();
        check("queued_entry", 32'(busy_out), 32'd1);
        run_stream(2, "queued");

        // B accepted into the free bank, C dropped; B must be the next stream.
        write_frame(3, 1'b0);
        write_frame(4, 1'b0);
        check("drop_one", 32'(frames_dropped_out), StatsEn ? 32'd1 : 32'd0);
        pulse_kmeans_done();
        run_stream(3, "frame_b");

        // First pulse fills the free bank, the rest are drops.
        for (int i = 0; i < 100; i++) begin
            frame_done_in = 1'b1;
            tick();
            frame_done_in = 1'b0;
            tick();
        end
        check("drop_100", 32'(frames_dropped_out), StatsEn ? 32'd100 : 32'd0);
        for (int i = 0; i < 201; i++) begin
            frame_done_in = 1'b1;
            tick();
            frame_done_in = 1'b0;
            tick();
        end
        check("drop_sat", 32'(frames_dropped_out), StatsEn ? 32'd255 : 32'd0);

        // Reset in the middle of the stream of the pending frame.
        pulse_kmeans_done();
        viol = 0;
        while (!busy_out && viol < 100) begin
            tick();
            viol++;
        end
        repeat (3 + 100) tick();
        check("mid_pos", {15'd0, x_out, y_out}, {15'd0, 9'd100, 8'd0});
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        check("mid_rst_out",
              {12'd0, x_out, y_out, data_valid_out, new_frame_out, busy_out, frames_dropped_out},
              32'd0);
        viol = 0;
        for (int i = 0; i < 1500; i++) begin
            if (busy_out || new_frame_out || data_valid_out) viol++;
            tick();
        end
        check("mid_no_replay", 32'(viol), 32'd0);

        // Out-of-range pixels must not leak into the stored frame.
        write_frame(5, 1'b1);
        run_stream(5, "oor");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
